// File: rtl/hamming_rx_ctrl_if.sv
// Handshake bundle for the Hamming(7,4) receive controller.
// Input side : in_valid/in_ready carry a 7-bit codeword plus the corr_en mode bit.
// Output side: out_valid/out_ready carry the 4 data bits, syndrome and corrected flag.
// master = producer/consumer environment, slave = the controller.
interface hamming_rx_ctrl_if;
  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              corr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SYN_W-1:0]  out_syn;
  logic              out_corr;

  modport master (
    output in_valid, in_code, corr_en, out_ready,
    input  in_ready, out_valid, out_data, out_syn, out_corr
  );

  modport slave (
    input  in_valid, in_code, corr_en, out_ready,
    output in_ready, out_valid, out_data, out_syn, out_corr
  );
endinterface

// File: rtl/hamming_rx_ctrl.sv
// Hamming(7,4) receive sequencing controller.
// Registers one codeword per transaction, computes its syndrome, optionally
// corrects a single-bit error, and returns the data bits with status.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   bus       - slave side of hamming_rx_ctrl_if (input and output handshakes)
//   err_count - saturating count of words that had a bit corrected
module hamming_rx_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  hamming_rx_ctrl_if.slave bus,
  output logic [CNT_W-1:0] err_count
);
  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  typedef enum logic [1:0] {IDLE, CHECK, FIX, OUT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CODE_W-1:0] w;
  logic [CODE_W-1:0] w_fix;
  logic [SYN_W-1:0]  syn;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SYN_W-1:0]  out_syn;
  logic              out_corr;

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] x);
    return {x[6], x[5], x[4], x[2]};
  endfunction

  // Syndrome of the held word and the word with the indicated bit flipped.
  always_comb begin
    syn[0] = w[0] ^ w[2] ^ w[4] ^ w[6];
    syn[1] = w[1] ^ w[2] ^ w[5] ^ w[6];
    syn[2] = w[3] ^ w[4] ^ w[5] ^ w[6];
    w_fix  = w;
    if (syn != SYN_W'(0)) begin
      w_fix = w ^ CODE_W'(CODE_W'(1) << (syn - SYN_W'(1)));
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid && in_ready) state_nxt = CHECK;
      CHECK:   state_nxt = ((syn != SYN_W'(0)) && bus.corr_en) ? FIX : OUT;
      FIX:     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, registered handshake flags and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      w         <= '0;
      out_data  <= '0;
      out_syn   <= '0;
      out_corr  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == OUT);
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            w        <= bus.in_code;
            out_corr <= 1'b0;
          end
        end
        CHECK: begin
          out_syn <= syn;
          if (state_nxt == OUT) out_data <= extract(w);
        end
        FIX: begin
          w        <= w_fix;
          out_data <= extract(w_fix);
          out_corr <= 1'b1;
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_syn   = out_syn;
  assign bus.out_corr  = out_corr;
endmodule
